ofs_plat_utils_ccip_bmask_wr_splitter: RTL and testbench
========================================================

# ofs_plat_utils_ccip_bmask_wr_splitter

Sequencer that converts one write request carrying an arbitrary 64-byte mask into the minimal series of CCI-P writes. The mask may come from Avalon or AXI and may be non-contiguous. A CCI-P byte-mode write can express only one contiguous byte range, so each maximal contiguous run of set mask bits becomes one output write. The block sits between the AFU-side write channel and the CCI-P c1 TX request generator in the host-channel shims.

## Interface
Parameters:
- TAG_WIDTH, default 16: width of the opaque per-request tag carried to every output piece.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous reset, active low.
- in_valid  in  1  write request valid.
- in_ready  out  1  block can accept a request.
- in_addr  in  t_ccip_clAddr  line address.
- in_data  in  CCIP_CLDATA_WIDTH  line data.
- in_bmask  in  CCIP_CLDATA_BYTE_WIDTH (64)  byte enables; bit i = byte i.
- in_tag  in  TAG_WIDTH  opaque tag.
- out_valid  out  1  output write valid.
- out_ready  in  1  consumer accepts the output write.
- out_addr  out  t_ccip_clAddr  copy of in_addr.
- out_data  out  CCIP_CLDATA_WIDTH  copy of in_data (full line, unshifted).
- out_wr_mode  out  t_ccip_mem_access_mode  eMOD_CL or eMOD_BYTE.
- out_byte_start  out  t_ccip_clByteIdx  first byte of the run.
- out_byte_len  out  t_ccip_clByteIdx  run length, 1..63.
- out_last  out  1  final piece of the current request.
- out_tag  out  TAG_WIDTH  copy of in_tag.
- zero_mask_drop  out  1  one-cycle pulse: a request with all-zero mask was consumed.

## Operation
- Single-entry holding register stores addr, data, tag and the remaining mask (rem_mask).
- FSM states:
  - IDLE: in_ready=1. On an in_valid handshake, load the holding register with rem_mask=in_bmask and go to SCAN.
  - SCAN: evaluate rem_mask.
    - All ones: register out_wr_mode=eMOD_CL, start=0, len=0, last=1; go to EMIT.
    - Zero (only possible on first scan): pulse zero_mask_drop; go to IDLE; emit nothing.
    - Otherwise: find the lowest run [s..e]. Register eMOD_BYTE, start=s, len=e-s+1 (6-bit, never 0 or 64), and last=1 when no set bit lies above e. Go to EMIT.
  - EMIT: out_valid=1. On out_ready, clear bits s..e in rem_mask (clear all for CL mode). Go to IDLE if last, else SCAN.
- Full-line detection is exact equality with all ones. A mask with bits 0 and 63 set but a gap inside is split, not treated as full.
- Pieces are emitted in ascending byte order.
- addr, data and tag are identical on every piece of one request.
- in_ready is 0 in SCAN and EMIT. There is no overlap between requests.

## Timing
- Request accepted at cycle N.
- First out_valid at N+2.
- After a piece's out_ready handshake at cycle M, the next piece is valid at M+2, or in_ready=1 at M+1 after the last piece.
- A request with k runs occupies at least 2k+1 cycles. Zero-mask requests take 2 cycles: zero_mask_drop pulses at N+1, in_ready=1 at N+2.
- While out_valid=1 and out_ready=0, all out_* fields are held stable.
- Reset (asynchronous, any state, including mid-split):
  - State goes to IDLE; rem_mask is cleared.
  - out_valid, zero_mask_drop and all out_* fields go to 0.
  - in_ready is 0 while reset_n is low and 1 on the first cycle after deassertion.
  - A partially emitted request is abandoned and not resumed.

## Structure
- Package ofs_plat_utils_ccip_bmask_pkg holds:
  - the FSM state enum (IDLE, SCAN, EMIT);
  - the t_bmask_run struct (start, len, full, empty, last) using t_ccip_clByteIdx.
- CCI-P types come from the existing CCI-P package.
- One sub-module, ofs_plat_utils_ccip_bmask_first_run: combinational. Input is the 64-bit mask; outputs are t_bmask_run plus the run-clear mask. It is instantiated once, its output registered in SCAN.

## Test plan
- bmask=64'hFFFF_FFFF_FFFF_FFFF -> one piece: eMOD_CL, start=0, len=0, last=1, valid at N+2.
- bmask=64'h0000_0000_0000_0F00 -> one piece: eMOD_BYTE, start=8, len=4, last=1.
- bmask=64'h8000_0000_0000_0001 -> two pieces:
  - (start=0, len=1, last=0);
  - (start=63, len=1, last=1), valid 2 cycles after the first handshake.
  - addr, data and tag are equal on both.
- bmask=64'h7FFF_FFFF_FFFF_FFFF -> one eMOD_BYTE piece, start=0, len=63.
- bmask=0 -> no out_valid, zero_mask_drop pulse at N+1, in_ready=1 at N+2.
- bmask=64'h5 with out_ready low for 5 cycles, then reset_n pulsed low mid-EMIT -> fields stable while stalled; after reset out_valid=0, in_ready=1, and a new request is processed normally.

Source files
------------

// File: rtl/ofs_plat_utils_ccip_bmask_pkg.sv
// Types shared by the byte-mask write splitter: local CCI-P line/byte types,
// the splitter FSM encoding and the per-run descriptor.
package ofs_plat_utils_ccip_bmask_pkg;

  localparam int CCIP_CLADDR_WIDTH      = 42;
  localparam int CCIP_CLDATA_WIDTH      = 512;
  localparam int CCIP_CLDATA_BYTE_WIDTH = CCIP_CLDATA_WIDTH / 8;

  typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
  typedef logic [5:0]                   t_ccip_clByteIdx;

  typedef enum logic [1:0] {
    eMOD_CL   = 2'b00,
    eMOD_BYTE = 2'b01
  } t_ccip_mem_access_mode;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } t_bmask_state;

  // Lowest contiguous run of a mask; len is 0 for a full line.
  typedef struct packed {
    t_ccip_clByteIdx start;
    t_ccip_clByteIdx len;
    logic            full;
    logic            empty;
    logic            last;
  } t_bmask_run;

endpackage

// File: rtl/ofs_plat_utils_ccip_bmask_wr_splitter_if.sv
// Write-request in / CCI-P write-piece out bundle for the byte-mask splitter.
interface ofs_plat_utils_ccip_bmask_wr_splitter_if
  import ofs_plat_utils_ccip_bmask_pkg::*;
#(
  parameter int TAG_WIDTH = 16
) ();

  logic                              in_valid;
  logic                              in_ready;
  t_ccip_clAddr                      in_addr;
  logic [CCIP_CLDATA_WIDTH-1:0]      in_data;
  logic [CCIP_CLDATA_BYTE_WIDTH-1:0] in_bmask;
  logic [TAG_WIDTH-1:0]              in_tag;

  logic                              out_valid;
  logic                              out_ready;
  t_ccip_clAddr                      out_addr;
  logic [CCIP_CLDATA_WIDTH-1:0]      out_data;
  t_ccip_mem_access_mode             out_wr_mode;
  t_ccip_clByteIdx                   out_byte_start;
  t_ccip_clByteIdx                   out_byte_len;
  logic                              out_last;
  logic [TAG_WIDTH-1:0]              out_tag;

  logic                              zero_mask_drop;

  modport master (
    output in_valid, in_addr, in_data, in_bmask, in_tag, out_ready,
    input  in_ready, out_valid, out_addr, out_data, out_wr_mode,
           out_byte_start, out_byte_len, out_last, out_tag, zero_mask_drop
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_bmask, in_tag, out_ready,
    output in_ready, out_valid, out_addr, out_data, out_wr_mode,
           out_byte_start, out_byte_len, out_last, out_tag, zero_mask_drop
  );

endinterface

// File: rtl/ofs_plat_utils_ccip_bmask_first_run.sv
// Combinational finder for the lowest contiguous run of set bits in a
// 64-bit byte mask, plus the mask of the bits that run covers.
module ofs_plat_utils_ccip_bmask_first_run
  import ofs_plat_utils_ccip_bmask_pkg::*;
(
  input  logic [CCIP_CLDATA_BYTE_WIDTH-1:0] mask,
  output t_bmask_run                        run,
  output logic [CCIP_CLDATA_BYTE_WIDTH-1:0] clr_mask
);

  logic [CCIP_CLDATA_BYTE_WIDTH-1:0] lsb;
  logic [CCIP_CLDATA_BYTE_WIDTH-1:0] run_bits;
  logic [6:0]                        cnt;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    run      = '0;
    cnt      = '0;
    // Adding the isolated low bit ripples a carry through exactly the
    // lowest run, so the bits that flip to zero are that run.
    lsb      = mask & (~mask + 64'd1);
    run_bits = mask & ~(mask + lsb);

    for (int i = 0; i < CCIP_CLDATA_BYTE_WIDTH; i++) begin
      if (lsb[i]) run.start = 6'(i);
      cnt = cnt + 7'(run_bits[i]);
    end

    run.full  = &mask;
    run.empty = ~|mask;
    run.len   = cnt[5:0];
    run.last  = ~|(mask & ~run_bits);
    clr_mask  = run_bits;
  end

endmodule

// File: rtl/ofs_plat_utils_ccip_bmask_wr_splitter.sv
// Splits one write with an arbitrary 64-byte mask into CCI-P writes: a full
// line write, or one byte-mode write per contiguous run in ascending order.
module ofs_plat_utils_ccip_bmask_wr_splitter
  import ofs_plat_utils_ccip_bmask_pkg::*;
#(
  parameter int TAG_WIDTH = 16
) (
  input logic clk,
  input logic reset_n,
  ofs_plat_utils_ccip_bmask_wr_splitter_if.slave bus
);

  t_bmask_state state, state_nxt;

  t_ccip_clAddr                      addr_q;
  logic [CCIP_CLDATA_WIDTH-1:0]      data_q;
  logic [TAG_WIDTH-1:0]              tag_q;
  logic [CCIP_CLDATA_BYTE_WIDTH-1:0] rem_mask;
  logic [CCIP_CLDATA_BYTE_WIDTH-1:0] clr_q;

  t_ccip_mem_access_mode mode_q;
  t_ccip_clByteIdx       start_q;
  t_ccip_clByteIdx       len_q;
  logic                  last_q;

  t_bmask_run                        run;
  logic [CCIP_CLDATA_BYTE_WIDTH-1:0] run_clr;
  logic                              in_hs;
  logic                              out_hs;

  ofs_plat_utils_ccip_bmask_first_run u_first_run (
    .mask     (rem_mask),
    .run      (run),
    .clr_mask (run_clr)
  );

  assign in_hs  = bus.in_valid && bus.in_ready;
  assign out_hs = (state == EMIT) && bus.out_ready;

  // NOTE: state and datapath registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_hs) state_nxt = SCAN;
      SCAN: state_nxt = run.empty ? IDLE : EMIT;
      EMIT: if (bus.out_ready) state_nxt = last_q ? IDLE : SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the line data register is reset too, because every out_* field must read 0 in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      data_q   <= '0;
      tag_q    <= '0;
      rem_mask <= '0;
      clr_q    <= '0;
      mode_q   <= eMOD_CL;
      start_q  <= '0;
      len_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      if ((state == IDLE) && in_hs) begin
        addr_q   <= bus.in_addr;
        data_q   <= bus.in_data;
        tag_q    <= bus.in_tag;
        rem_mask <= bus.in_bmask;
      end

      if ((state == SCAN) && !run.empty) begin
        mode_q  <= run.full ? eMOD_CL : eMOD_BYTE;
        start_q <= run.full ? '0 : run.start;
        len_q   <= run.full ? '0 : run.len;
        last_q  <= run.full | run.last;
        clr_q   <= run_clr;
      end

      if (out_hs) rem_mask <= rem_mask & ~clr_q;
    end
  end

  // in_ready is gated by reset_n so it reads 0 for the whole reset pulse.
  assign bus.in_ready       = reset_n && (state == IDLE);
  assign bus.out_valid      = (state == EMIT);
  assign bus.zero_mask_drop = (state == SCAN) && run.empty;
  assign bus.out_addr       = addr_q;
  assign bus.out_data       = data_q;
  assign bus.out_tag        = tag_q;
  assign bus.out_wr_mode    = mode_q;
  assign bus.out_byte_start = start_q;
  assign bus.out_byte_len   = len_q;
  assign bus.out_last       = last_q;

endmodule

// File: tb/tb_ofs_plat_utils_ccip_bmask_wr_splitter.sv
// Scoreboard bench for the byte-mask write splitter: directed and random
// masks, random output back-pressure, and a mid-split reset.
module tb_ofs_plat_utils_ccip_bmask_wr_splitter;
  import ofs_plat_utils_ccip_bmask_pkg::*;

  localparam int TW = 16;

  typedef struct {
    bit                           drop;
    t_ccip_mem_access_mode        mode;
    int                           start;
    int                           len;
    bit                           last;
    t_ccip_clAddr                 addr;
    logic [CCIP_CLDATA_WIDTH-1:0] data;
    logic [TW-1:0]                tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   force_stall = 1'b0;
  exp_t exp_q[$];

  ofs_plat_utils_ccip_bmask_wr_splitter_if #(.TAG_WIDTH(TW)) bus ();

  ofs_plat_utils_ccip_bmask_wr_splitter #(.TAG_WIDTH(TW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    check(name, act === req, act, req);
  endtask

  // Reference: walk the mask bit by bit and emit one piece per maximal run.
  function automatic void model_push(input logic [63:0] m, input t_ccip_clAddr a,
                                     input logic [CCIP_CLDATA_WIDTH-1:0] d, input logic [TW-1:0] t);
    exp_t e;
    exp_t pieces[$];
    int   i;
    int   s;
    e = '{drop: 1'b0, mode: eMOD_BYTE, start: 0, len: 0, last: 1'b0, addr: a, data: d, tag: t};
    if (m == '1) begin
      e.mode = eMOD_CL;
      e.last = 1'b1;
      exp_q.push_back(e);
    end else if (m == '0) begin
      e.drop = 1'b1;
      exp_q.push_back(e);
    end else begin
      i = 0;
      while (i < 64) begin
        if (m[i]) begin
          s = i;
          while (i < 64 && m[i]) i++;
          e.start = s;
          e.len   = i - s;
          pieces.push_back(e);
        end else begin
          i++;
        end
      end
      pieces[pieces.size()-1].last = 1'b1;
      foreach (pieces[k]) exp_q.push_back(pieces[k]);
    end
  endfunction

  function automatic logic [CCIP_CLDATA_WIDTH-1:0] rand_line();
    logic [CCIP_CLDATA_WIDTH-1:0] d;
    for (int w = 0; w < CCIP_CLDATA_WIDTH / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [63:0] rand_mask();
    logic [64:0] r;
    int          s;
    int          l;
    case ($urandom_range(0, 5))
      0: return {$urandom, $urandom};
      1: return '1;
      2: return '0;
      3: begin
        s = $urandom_range(0, 63);
        l = $urandom_range(1, 64 - s);
        r = ((65'd1 << l) - 65'd1) << s;
        return r[63:0];
      end
      4: return {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      default: return ~(64'd1 << $urandom_range(0, 63));
    endcase
  endfunction

  // Present one request, push its expected pieces once the handshake is certain.
  task automatic send(input logic [63:0] m);
    t_ccip_clAddr                 a;
    logic [CCIP_CLDATA_WIDTH-1:0] d;
    logic [TW-1:0]                t;
    bit                           taken;
    a = t_ccip_clAddr'({$urandom, $urandom});
    d = rand_line();
    t = TW'($urandom);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_bmask = m;
    bus.in_tag   = t;
    taken = 1'b0;
    for (int i = 0; i < 400 && !taken; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_push(m, a, d, t);
        taken = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("accept_timeout", taken, 64'(taken), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Output back-pressure.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each output event and checks cycle timing.
  initial begin
    exp_t                         e;
    bit                           new_piece;
    bit                           prev_stall;
    int                           last_evt;
    int                           pend_rdy;
    t_ccip_clAddr                 s_addr;
    logic [CCIP_CLDATA_WIDTH-1:0] s_data;
    logic [TW-1:0]                s_tag;
    logic [1:0]                   s_mode;
    logic [5:0]                   s_start;
    logic [5:0]                   s_len;
    logic                         s_last;
    new_piece  = 1'b1;
    prev_stall = 1'b0;
    last_evt   = 0;
    pend_rdy   = -1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        new_piece  = 1'b1;
        prev_stall = 1'b0;
        pend_rdy   = -1;
      end else begin
        if (pend_rdy == cyc) check_eq("in_ready_after_done", 64'(bus.in_ready), 64'd1);
        if (bus.in_valid && bus.in_ready) begin
          last_evt  = cyc;
          new_piece = 1'b1;
        end
        if (bus.zero_mask_drop) begin
          check("drop_expected", exp_q.size() != 0, 64'(exp_q.size()), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("drop_kind", 64'(e.drop), 64'd1);
          end
          check_eq("drop_cycle", 64'(cyc), 64'(last_evt + 1));
          pend_rdy = cyc + 1;
        end
        if (bus.out_valid) begin
          if (prev_stall) begin
            check("stable_while_stalled",
                  s_addr == bus.out_addr && s_data == bus.out_data && s_tag == bus.out_tag &&
                  s_mode == bus.out_wr_mode && s_start == bus.out_byte_start &&
                  s_len == bus.out_byte_len && s_last == bus.out_last,
                  {32'(bus.out_byte_start), 32'(bus.out_byte_len)}, {32'(s_start), 32'(s_len)});
          end
          if (new_piece) begin
            check_eq("valid_cycle", 64'(cyc), 64'(last_evt + 2));
            new_piece = 1'b0;
          end
          if (bus.out_ready) begin
            check("piece_expected", exp_q.size() != 0, 64'(exp_q.size()), 64'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check_eq("piece_kind", 64'(e.drop), 64'd0);
              check_eq("wr_mode", 64'(bus.out_wr_mode), 64'(e.mode));
              check_eq("byte_start", 64'(bus.out_byte_start), 64'(e.start));
              check_eq("byte_len", 64'(bus.out_byte_len), 64'(e.len & 63));
              check_eq("last", 64'(bus.out_last), 64'(e.last));
              check_eq("addr", 64'(bus.out_addr), 64'(e.addr));
              check_eq("tag", 64'(bus.out_tag), 64'(e.tag));
              check("data", bus.out_data == e.data, bus.out_data[63:0], e.data[63:0]);
              if (e.last) pend_rdy = cyc + 1;
            end
            last_evt   = cyc;
            new_piece  = 1'b1;
            prev_stall = 1'b0;
          end else begin
            prev_stall = 1'b1;
            s_addr     = bus.out_addr;
            s_data     = bus.out_data;
            s_tag      = bus.out_tag;
            s_mode     = bus.out_wr_mode;
            s_start    = bus.out_byte_start;
            s_len      = bus.out_byte_len;
            s_last     = bus.out_last;
          end
        end else if (prev_stall) begin
          check("valid_held_while_stalled", 1'b0, 64'd0, 64'd1);
          prev_stall = 1'b0;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bit seen;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.in_bmask = '0;
    bus.in_tag   = '0;

    repeat (3) @(posedge clk);
    #2;
    check_eq("reset_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("reset_drop", 64'(bus.zero_mask_drop), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check_eq("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    send(64'hFFFF_FFFF_FFFF_FFFF);
    send(64'h0000_0000_0000_0F00);
    send(64'h8000_0000_0000_0001);
    send(64'h7FFF_FFFF_FFFF_FFFF);
    send(64'h0);
    send(64'h8000_0000_0000_0000);
    send(64'hF0F0_0000_0000_0001);

    for (int n = 0; n < 60; n++) send(rand_mask());

    // Stall a two-run request on its first piece, then reset mid-EMIT.
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    force_stall = 1'b1;
    @(posedge clk);
    send(64'h5);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    check_eq("stall_valid_seen", 64'(seen), 64'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("mid_reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("mid_reset_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("mid_reset_drop", 64'(bus.zero_mask_drop), 64'd0);
    check_eq("mid_reset_start", 64'(bus.out_byte_start), 64'd0);
    check_eq("mid_reset_len", 64'(bus.out_byte_len), 64'd0);
    check_eq("mid_reset_last", 64'(bus.out_last), 64'd0);
    check_eq("mid_reset_addr", 64'(bus.out_addr), 64'd0);
    check_eq("mid_reset_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    force_stall = 1'b0;
    #1;
    check_eq("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("post_reset_out_valid", 64'(bus.out_valid), 64'd0);

    send(64'h5);
    send(64'h0000_FF00_0000_00FF);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
